// File: rtl/bus_register_bank_pkg.sv
// Shared constants for the bus register bank: default geometry and the
// register slots the control sequencer addresses by name.
package bus_register_bank_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREGS = 16;
  localparam int DEF_SEL_W = 4;

  typedef enum logic [3:0] {
    REG_A   = 4'd0,
    REG_B   = 4'd1,
    REG_OUT = 4'd2,
    REG_MAR = 4'd3,
    REG_IR  = 4'd4,
    REG_PC  = 4'd9
  } reg_idx_e;

  localparam int DEF_PC_SEL = int'(REG_PC);

endpackage

// File: rtl/bus_register_bank_if.sv
// Bus-side signals of the register bank; the sequencer/bench is the master.
interface bus_register_bank_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
);
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] in;
  logic             go;
  logic             load;
  logic             OE;
  logic             CE;
  logic             HLT;
  logic [WIDTH-1:0] Bus_out;
  logic [WIDTH-1:0] curr;
  logic [WIDTH-1:0] count;
  logic             on;
  logic             ack;
  logic             sel_err;

  modport master (
    output sel, in, go, load, OE, CE, HLT,
    input  Bus_out, curr, count, on, ack, sel_err
  );

  modport slave (
    input  sel, in, go, load, OE, CE, HLT,
    output Bus_out, curr, count, on, ack, sel_err
  );
endinterface

// File: rtl/bus_register_bank_go_edge_sync.sv
// Rising-edge detector for the commit strobe plus the one-cycle acknowledge.
// go_q is loaded during reset so a strobe held through reset never fires.
module go_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic go_i,
  output logic go_edge_o,
  output logic ack_o
);

  logic go_q;
  logic ack_q;

  assign go_edge_o = go_i & ~go_q;
  assign ack_o     = ack_q;

  always_ff @(posedge clk_i) begin
    go_q <= go_i;
    if (rst_i) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= go_edge_o;
    end
  end

endmodule

// File: rtl/bus_register_bank.sv
// Selectable bank of bus registers; one slot doubles as a program counter
// with count enable and a sticky halt.
module bus_register_bank
  import bus_register_bank_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NREGS  = DEF_NREGS,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int PC_SEL = DEF_PC_SEL
) (
  input logic               CLK,
  input logic               RESET,
  bus_register_bank_if.slave bus
);

  if (NREGS > (2 ** SEL_W) || PC_SEL >= NREGS || NREGS < 2) begin : g_bad_params
    $error("bus_register_bank: illegal NREGS/SEL_W/PC_SEL combination");
  end

  localparam logic [SEL_W:0] NREGS_W = NREGS[SEL_W:0];

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             halted_q;
  logic             halted_d;
  logic             go_edge;
  logic             sel_err;
  logic             write_en;
  logic             pc_inc;
  logic [WIDTH-1:0] curr;

  go_edge_sync u_go_edge_sync (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .go_i      (bus.go),
    .go_edge_o (go_edge),
    .ack_o     (bus.ack)
  );

  assign sel_err  = ({1'b0, bus.sel} >= NREGS_W);
  assign write_en = go_edge & bus.load & ~sel_err;
  // Halt requested this cycle already suppresses the increment.
  assign pc_inc   = bus.CE & ~halted_q & ~bus.HLT;
  assign halted_d = halted_q | bus.HLT;

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (pc_inc) begin
      regs_d[PC_SEL] = regs_q[PC_SEL] + WIDTH'(1);
    end
    for (int i = 0; i < NREGS; i++) begin
      if (write_en && bus.sel == i[SEL_W-1:0]) begin
        regs_d[i] = bus.in;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      halted_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      halted_q <= halted_d;
    end
  end

  always_comb begin
    curr = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.sel == i[SEL_W-1:0]) begin
        curr = regs_q[i];
      end
    end
  end

  assign bus.curr    = curr;
  assign bus.Bus_out = bus.OE ? curr : '0;
  assign bus.count   = regs_q[PC_SEL];
  assign bus.on      = ~halted_q;
  assign bus.sel_err = sel_err;

endmodule

// File: tb/tb_bus_register_bank.sv
// Directed bench for bus_register_bank: default 8-bit bank, a 12-entry bank
// for out-of-range selects, and a 16-bit 4-entry bank with PC in slot 0.
module tb_bus_register_bank;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  always #5 CLK = ~CLK;

  bus_register_bank_if #(.WIDTH(8),  .SEL_W(4)) busA ();
  bus_register_bank_if #(.WIDTH(8),  .SEL_W(4)) busB ();
  bus_register_bank_if #(.WIDTH(16), .SEL_W(2)) busC ();

  bus_register_bank #(.WIDTH(8), .NREGS(16), .SEL_W(4), .PC_SEL(9)) dutA (
    .CLK(CLK), .RESET(RESET), .bus(busA)
  );
  bus_register_bank #(.WIDTH(8), .NREGS(12), .SEL_W(4), .PC_SEL(9)) dutB (
    .CLK(CLK), .RESET(RESET), .bus(busB)
  );
  bus_register_bank #(.WIDTH(16), .NREGS(4), .SEL_W(2), .PC_SEL(0)) dutC (
    .CLK(CLK), .RESET(RESET), .bus(busC)
  );

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic applyStimulus();
    @(posedge CLK);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    busA.sel = '0; busA.in = '0; busA.go = 0; busA.load = 0;
    busA.OE = 0; busA.CE = 0; busA.HLT = 0;
    busB.sel = '0; busB.in = '0; busB.go = 0; busB.load = 0;
    busB.OE = 0; busB.CE = 0; busB.HLT = 0;
    busC.sel = '0; busC.in = '0; busC.go = 0; busC.load = 0;
    busC.OE = 0; busC.CE = 0; busC.HLT = 0;

    // Reset with go held high through release
    RESET = 1; busA.go = 1; busA.sel = 4'd9; busA.in = 8'h77; busA.load = 1; busA.OE = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_count", 32'(busA.count), 32'h00);
    checkOutput("rst_on", 32'(busA.on), 32'h1);
    checkOutput("rst_ack", 32'(busA.ack), 32'h0);
    checkOutput("rst_bus", 32'(busA.Bus_out), 32'h00);
    RESET = 0;
    applyStimulus();
    checkOutput("rel_ack", 32'(busA.ack), 32'h0);
    checkOutput("rel_count", 32'(busA.count), 32'h00);
    applyStimulus();
    checkOutput("rel_ack2", 32'(busA.ack), 32'h0);
    checkOutput("rel_bus", 32'(busA.Bus_out), 32'h00);
    checkOutput("rel_on", 32'(busA.on), 32'h1);
    busA.go = 0;
    applyStimulus();

    // Write and readback, go held three cycles
    busA.sel = 4'd3; busA.in = 8'hAA; busA.load = 1; busA.go = 1;
    applyStimulus();
    checkOutput("wr_curr", 32'(busA.curr), 32'hAA);
    checkOutput("wr_bus_oe", 32'(busA.Bus_out), 32'hAA);
    checkOutput("wr_ack1", 32'(busA.ack), 32'h1);
    busA.in = 8'hBB;
    applyStimulus();
    checkOutput("wr_ack2", 32'(busA.ack), 32'h0);
    applyStimulus();
    checkOutput("wr_ack3", 32'(busA.ack), 32'h0);
    checkOutput("wr_hold_curr", 32'(busA.curr), 32'hAA);
    busA.OE = 0;
    #1;
    checkOutput("wr_bus_noe", 32'(busA.Bus_out), 32'h00);
    checkOutput("wr_curr_noe", 32'(busA.curr), 32'hAA);
    busA.go = 0;
    applyStimulus();

    // PC load and wrap
    busA.sel = 4'd9; busA.in = 8'hFE; busA.go = 1;
    applyStimulus();
    checkOutput("pc_load", 32'(busA.count), 32'hFE);
    busA.go = 0; busA.load = 0; busA.CE = 1;
    applyStimulus();
    checkOutput("pc_ff", 32'(busA.count), 32'hFF);
    applyStimulus();
    checkOutput("pc_wrap", 32'(busA.count), 32'h00);
    applyStimulus();
    checkOutput("pc_01", 32'(busA.count), 32'h01);

    // Write beats increment, halt beats increment, writes work while halted
    busA.in = 8'h40; busA.load = 1; busA.go = 1;
    applyStimulus();
    checkOutput("prio_wr", 32'(busA.count), 32'h40);
    busA.go = 0; busA.HLT = 1;
    applyStimulus();
    checkOutput("halt_count", 32'(busA.count), 32'h40);
    checkOutput("halt_on", 32'(busA.on), 32'h0);
    busA.HLT = 0;
    applyStimulus();
    checkOutput("halt_sticky_on", 32'(busA.on), 32'h0);
    checkOutput("halt_sticky_cnt", 32'(busA.count), 32'h40);
    busA.in = 8'h10; busA.go = 1;
    applyStimulus();
    checkOutput("halt_wr", 32'(busA.count), 32'h10);
    busA.go = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("halt_hold", 32'(busA.count), 32'h10);
    busA.sel = 4'd3;
    #1;
    checkOutput("nonpc_keep", 32'(busA.curr), 32'hAA);
    RESET = 1;
    applyStimulus();
    checkOutput("rst2_count", 32'(busA.count), 32'h00);
    checkOutput("rst2_on", 32'(busA.on), 32'h1);
    checkOutput("rst2_reg3", 32'(busA.curr), 32'h00);
    RESET = 0; busA.CE = 0;
    applyStimulus();

    // Out-of-range select on 12-entry bank, and back-to-back acks
    busB.sel = 4'd5; busB.in = 8'h33; busB.load = 1; busB.go = 1;
    applyStimulus();
    checkOutput("oor_pre_ack", 32'(busB.ack), 32'h1);
    busB.go = 0;
    applyStimulus();
    checkOutput("oor_ack_low", 32'(busB.ack), 32'h0);
    busB.sel = 4'd13; busB.in = 8'h55; busB.OE = 1; busB.go = 1;
    #1;
    checkOutput("oor_sel_err", 32'(busB.sel_err), 32'h1);
    checkOutput("oor_curr", 32'(busB.curr), 32'h00);
    checkOutput("oor_bus", 32'(busB.Bus_out), 32'h00);
    applyStimulus();
    checkOutput("oor_ack", 32'(busB.ack), 32'h1);
    busB.sel = 4'd12;
    #1;
    checkOutput("oor_sel12_err", 32'(busB.sel_err), 32'h1);
    busB.sel = 4'd11;
    #1;
    checkOutput("oor_sel11_err", 32'(busB.sel_err), 32'h0);
    busB.sel = 4'd5;
    #1;
    checkOutput("oor_reg5", 32'(busB.curr), 32'h33);
    checkOutput("oor_count", 32'(busB.count), 32'h00);
    busB.go = 0;
    applyStimulus();
    busB.load = 0; busB.in = 8'h99; busB.go = 1;
    applyStimulus();
    checkOutput("noload_ack", 32'(busB.ack), 32'h1);
    checkOutput("noload_reg5", 32'(busB.curr), 32'h33);
    busB.go = 0;

    // 16-bit, 4-entry bank with the PC in slot 0
    busC.sel = 2'd2; busC.in = 16'hBEEF; busC.load = 1; busC.go = 1; busC.OE = 1;
    applyStimulus();
    checkOutput("w16_curr", 32'(busC.curr), 32'hBEEF);
    checkOutput("w16_ack", 32'(busC.ack), 32'h1);
    busC.go = 0;
    applyStimulus();
    busC.sel = 2'd0; busC.in = 16'hFFFF; busC.go = 1;
    applyStimulus();
    checkOutput("w16_pc_load", 32'(busC.count), 32'hFFFF);
    busC.go = 0; busC.CE = 1;
    applyStimulus();
    checkOutput("w16_pc_wrap", 32'(busC.count), 32'h0000);
    applyStimulus();
    checkOutput("w16_pc_1", 32'(busC.count), 32'h0001);
    busC.CE = 0; busC.sel = 2'd2;
    #1;
    checkOutput("w16_bus", 32'(busC.Bus_out), 32'hBEEF);
    busC.sel = 2'd3;
    #1;
    checkOutput("w16_reg3", 32'(busC.curr), 32'h0000);
    checkOutput("w16_sel_err", 32'(busC.sel_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bus_register_bank.md
Name: bus_register_bank

Overview:
Parametrised bank of NREGS bus-attached registers, each WIDTH bits, for the bus-based computer datapath. It replaces fixed 8-bit per-module registers with one selectable bank. One register slot is the program counter, with count-enable and sticky halt. Writes are committed by a rising-edge "go" strobe with a one-cycle acknowledge. Bus_out is zero unless the bank is output-enabled.

Parameters:
WIDTH, 8, data width of every register, of in, of Bus_out and of curr
NREGS, 16, number of registers (2..2**SEL_W)
SEL_W, 4, width of sel
PC_SEL, 9, index of the register that acts as program counter (< NREGS)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESET  input  1  synchronous active-high reset
sel  input  SEL_W  register select
in  input  WIDTH  write data
go  input  1  commit strobe, rising edge sampled
load  input  1  write enable qualifier for go
OE  input  1  drive selected register onto Bus_out
CE  input  1  program counter count enable
HLT  input  1  halt request, sticky
Bus_out  output  WIDTH  OE ? reg[sel] : 0
curr  output  WIDTH  reg[sel] regardless of OE (debug/display)
count  output  WIDTH  reg[PC_SEL]
on  output  1  1 = PC running, 0 = halted
ack  output  1  one-cycle pulse, cycle after an accepted go edge
sel_err  output  1  combinational, 1 when sel >= NREGS

Behaviour:
- Reset: one clock and one reset, CLK and RESET; reset is synchronous and active-high. On a RESET=1 edge:
  - all reg[i]=0, halted=0 (on=1), ack=0.
  - go_q<=go, so a go held high through reset release does not fire.
  - RESET overrides every other input that cycle.
- Edge detect: go_edge = go & ~go_q. go_q<=go every non-reset cycle. Holding go high produces exactly one commit.
- Write: on a cycle with go_edge=1, load=1 and sel<NREGS, reg[sel]<=in.
  - go_edge with load=0 or sel>=NREGS writes nothing.
  - ack pulses on the next cycle in all go_edge cases, so a handshake always completes.
- ack: registered, high for exactly one cycle per go_edge. A new go_edge directly after ack produces another ack.
- Program counter: reg[PC_SEL] <= reg[PC_SEL]+1 mod 2**WIDTH when CE=1, on=1, and no write targets PC_SEL this cycle.
  - A write to PC_SEL wins over increment (loads in, no +1).
  - Wrap: all-ones goes to 0, with no flag.
- Halt: HLT=1 at an edge sets halted. halted clears only on RESET.
  - HLT and CE in the same cycle: halt wins, no increment that cycle.
  - While halted, writes (including to PC_SEL) still work; only counting stops.
- Read path: purely combinational, zero latency.
  - curr=reg[sel] if sel<NREGS else 0.
  - Bus_out=curr when OE=1 else 0.
  - A written value is visible on curr/Bus_out the cycle after the commit edge.
- count always reflects reg[PC_SEL], independent of sel/OE.
- Non-PC registers never change except by write or reset.
- Elaboration check: NREGS<=2**SEL_W and PC_SEL<NREGS; otherwise the build fails.

Decomposition:
- Shared package: WIDTH/NREGS/SEL_W defaults, PC_SEL constant, and the register-index constants used by the control sequencer (PC, A, B, OUT, MAR, IR).
- One natural sub-module: go_edge_sync (registers go, emits go_edge and the delayed ack pulse, reset-loads go_q). The register array, PC increment and read mux stay in the top.

Test Plan:
- Reset with go held: RESET=1, go=1, sel=9 for 2 cycles, then RESET=0 with go still 1 -> no write, ack stays 0, count=0, on=1, Bus_out=0.
- Write/readback: sel=3, in=0xAA, load=1, go 0->1 held 3 cycles -> reg3=0xAA after one edge, ack high exactly 1 cycle; OE=1 gives Bus_out=0xAA, OE=0 gives Bus_out=0 while curr=0xAA.
- PC count and wrap: write 0xFE to sel=9, then CE=1 for 3 cycles -> count goes 0xFF, 0x00, 0x01.
- Priority: CE=1 with a go edge writing 0x40 to PC_SEL -> count=0x40 (no +1). Next cycle HLT=1 and CE=1 -> count stays 0x40, on=0. Later, with CE still 1, write 0x10 to PC -> count=0x10 and holds. RESET -> count=0, on=1.
- Out of range: NREGS=12, sel=13, load=1, go edge, in=0x55 -> no register changes, ack pulses, sel_err=1, curr=0, Bus_out=0 with OE=1.
- Generalised width: WIDTH=16, NREGS=4, SEL_W=2, PC_SEL=0 -> write 0xBEEF to reg2 is read back exactly; PC counts from 0xFFFF to 0x0000.
